// File: rtl/tb_multi_result_checker.sv
// Memory-write result checker: compares the first write to each of NUM_CHK word
// slots against an expected vector, counts mismatches and times the run.
module tb_multi_result_checker #(
  parameter int              ADDR_W    = 30,
  parameter int              DATA_W    = 32,
  parameter int              NUM_CHK   = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [15:0]     TIMEOUT   = 16'hFFFF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [DATA_W-1:0]         data,
  input  logic                      wen,
  input  logic [NUM_CHK*DATA_W-1:0] expected,
  output logic [7:0]                error_num,
  output logic [15:0]               duration,
  output logic [NUM_CHK-1:0]        checked,
  output logic                      finish,
  output logic                      pass,
  output logic                      timeout
);

  localparam int AXW = ADDR_W + 1;

  typedef enum logic {S_RUN, S_DONE} state_t;

  state_t              r_state;
  logic                r_wen_q;
  logic [7:0]          r_err;
  logic [15:0]         r_dur;
  logic [NUM_CHK-1:0]  r_checked;
  logic                r_timeout;

  logic                w_accept;
  logic [AXW-1:0]      w_addr_x;
  logic [AXW-1:0]      w_base_x;
  logic [AXW-1:0]      w_end_x;
  logic                w_in_win;
  logic [ADDR_W-1:0]   w_index;
  logic [NUM_CHK-1:0]  w_new;
  logic                w_mis;
  logic [NUM_CHK-1:0]  w_chk_nxt;
  logic                w_complete;
  logic                w_tmo;

  function automatic logic [7:0] f_sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [15:0] f_sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // A write held across a D-cache stall is only seen on its rising wen edge.
  assign w_accept = wen & ~r_wen_q;

  // Window bounds evaluated one bit wider so BASE_ADDR+NUM_CHK cannot wrap.
  assign w_addr_x = {1'b0, addr};
  assign w_base_x = {1'b0, BASE_ADDR};
  assign w_end_x  = w_base_x + AXW'(NUM_CHK);
  assign w_in_win = (w_addr_x >= w_base_x) && (w_addr_x < w_end_x);
  assign w_index  = addr - BASE_ADDR;

  always_comb begin
    w_new = '0;
    w_mis = 1'b0;
    for (int i = 0; i < NUM_CHK; i++) begin
      if (w_accept && w_in_win && (w_index == ADDR_W'(i)) && !r_checked[i]) begin
        w_new[i] = 1'b1;
        if (data != expected[i*DATA_W +: DATA_W]) w_mis = 1'b1;
      end
    end
  end

  assign w_chk_nxt  = r_checked | w_new;
  assign w_complete = &w_chk_nxt;
  // Completion on the same edge takes priority over the timeout.
  assign w_tmo      = (r_dur == TIMEOUT) && !w_complete;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_RUN;
      r_wen_q   <= 1'b0;
      r_err     <= 8'd0;
      r_dur     <= 16'd0;
      r_checked <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_wen_q <= wen;
      if (r_state == S_RUN) begin
        r_checked <= w_chk_nxt;
        if (w_mis) r_err <= f_sat_inc8(r_err);
        if (w_complete) begin
          r_state <= S_DONE;
        end else if (w_tmo) begin
          r_state   <= S_DONE;
          r_timeout <= 1'b1;
        end else begin
          r_dur <= f_sat_inc16(r_dur);
        end
      end
    end
  end

  assign error_num = r_err;
  assign duration  = r_dur;
  assign checked   = r_checked;
  assign timeout   = r_timeout;
  assign finish    = (r_state == S_DONE);
  assign pass      = finish && (r_err == 8'd0) && !r_timeout;

endmodule

// File: tb/tb_tb_multi_result_checker.sv
// Bench for tb_multi_result_checker: directed scenarios plus randomized writes,
// checked every cycle against a slot-level behavioural model.
module tb_tb_multi_result_checker;

  localparam int          AW   = 30;
  localparam int          DW   = 32;
  localparam int          NCHK = 2;
  localparam logic [AW-1:0] BASE = '0;
  localparam int          TMO  = 20;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [AW-1:0]          addr = '0;
  logic [DW-1:0]          data = '0;
  logic                   wen = 1'b0;
  logic [NCHK*DW-1:0]     expected = '0;
  logic [7:0]             error_num;
  logic [15:0]            duration;
  logic [NCHK-1:0]        checked;
  logic                   finish;
  logic                   pass;
  logic                   timeout;

  int n_chk  = 0;
  int n_fail = 0;

  tb_multi_result_checker #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_CHK(NCHK), .BASE_ADDR(BASE), .TIMEOUT(16'(TMO))
  ) dut (
    .clk(clk), .rst(rst), .addr(addr), .data(data), .wen(wen), .expected(expected),
    .error_num(error_num), .duration(duration), .checked(checked),
    .finish(finish), .pass(pass), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: per-slot "written" flags, first write judged, run timer.
  int       m_err, m_dur;
  bit [NCHK-1:0] m_chk;
  bit       m_done, m_tmo, m_prev_wen;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_err <= 0; m_dur <= 0; m_chk <= '0; m_done <= 0; m_tmo <= 0; m_prev_wen <= 0;
    end else begin : mdl
      bit            is_new_write;
      longint        slot;
      bit [NCHK-1:0] c;
      int            e;
      is_new_write = wen && !m_prev_wen;
      slot = longint'(addr) - longint'(BASE);
      c = m_chk;
      e = m_err;
      m_prev_wen <= wen;
      if (!m_done) begin
        if (is_new_write && slot >= 0 && slot < NCHK && !c[int'(slot)]) begin
          c[int'(slot)] = 1'b1;
          if (data != expected[int'(slot)*DW +: DW]) e = (e < 255) ? e + 1 : 255;
        end
        m_chk <= c;
        m_err <= e;
        if (c == {NCHK{1'b1}}) m_done <= 1'b1;
        else if (m_dur == TMO) begin
          m_done <= 1'b1;
          m_tmo  <= 1'b1;
        end else m_dur <= (m_dur < 65535) ? m_dur + 1 : 65535;
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    chk("cyc_error_num", error_num, m_err);
    chk("cyc_duration",  duration,  m_dur);
    chk("cyc_checked",   checked,   m_chk);
    chk("cyc_finish",    finish,    m_done);
    chk("cyc_timeout",   timeout,   m_tmo);
    chk("cyc_pass",      pass,      m_done && m_err == 0 && !m_tmo);
  end

  task automatic cyc(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    wen = w; addr = a; data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; wen = 1'b0; addr = '0; data = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    expected = {32'd5, 32'd60};
    do_reset();
    chk("rst_error_num", error_num, 0);
    chk("rst_duration",  duration,  0);
    chk("rst_checked",   checked,   0);
    chk("rst_finish",    {finish, pass, timeout}, 0);

    // Two clean single-cycle writes.
    idle(3);
    cyc(1'b1, 30'd0, 32'd60);
    idle(2);
    cyc(1'b1, 30'd1, 32'd5);
    chk("t1_error_num", error_num, 0);
    chk("t1_checked",   checked,   2'b11);
    chk("t1_finish",    finish,    1);
    chk("t1_pass",      pass,      1);
    chk("t1_duration",  duration,  6);

    // Stalled write held for four cycles counts once.
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 30'd0, 32'd60);
    idle(1);
    cyc(1'b1, 30'd1, 32'd5);
    chk("t2_error_num", error_num, 0);
    chk("t2_pass",      pass,      1);
    chk("t2_duration",  duration,  5);

    // First write wins even when wrong.
    do_reset();
    cyc(1'b1, 30'd0, 32'd61); idle(1);
    cyc(1'b1, 30'd0, 32'd60); idle(1);
    cyc(1'b1, 30'd1, 32'd5);
    chk("t3_error_num", error_num, 1);
    chk("t3_finish",    finish,    1);
    chk("t3_pass",      pass,      0);
    chk("t3_timeout",   timeout,   0);

    // Out-of-window writes only, run times out.
    do_reset();
    for (int i = 0; i < 20; i++)
      cyc(i % 3 == 0, (i % 2 == 0) ? 30'd7 : 30'd2, 32'd5);
    chk("t4_dur_20",   duration, 20);
    chk("t4_not_done", finish,   0);
    cyc(1'b0, 30'd0, 32'd0);
    chk("t4_timeout",  timeout,  1);
    chk("t4_finish",   finish,   1);
    chk("t4_pass",     pass,     0);
    chk("t4_checked",  checked,  0);
    chk("t4_error",    error_num, 0);
    idle(1);
    cyc(1'b1, 30'd0, 32'd60);
    chk("t4_frozen_dur", duration, 20);
    chk("t4_frozen_chk", checked,  0);

    // Completion on the timeout edge wins.
    do_reset();
    cyc(1'b1, 30'd0, 32'd60);
    idle(19);
    chk("t5_dur_20", duration, 20);
    cyc(1'b1, 30'd1, 32'd5);
    chk("t5_timeout",  timeout,  0);
    chk("t5_pass",     pass,     1);
    chk("t5_duration", duration, 20);

    // Asynchronous reset mid-run after a mismatch, then a clean rerun.
    do_reset();
    cyc(1'b1, 30'd0, 32'd99);
    chk("t6_err_before", error_num, 1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_async_err", error_num, 0);
    chk("t6_async_chk", checked,   0);
    chk("t6_async_dur", duration,  0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc(1'b1, 30'd1, 32'd5); idle(1);
    cyc(1'b1, 30'd0, 32'd60);
    chk("t6_rerun_pass", pass, 1);

    // Randomized runs with occasional mid-run resets.
    for (int r = 0; r < 60; r++) begin
      do_reset();
      rst = 1'b0;
      expected = {DW'($urandom_range(0, 15)), DW'($urandom_range(0, 15))};
      #1;
      rst = 1'b1;
      for (int k = 0, len = $urandom_range(4, 30); k < len; k++) begin
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        a = ($urandom_range(0, 9) < 8) ? AW'($urandom_range(0, 2)) : AW'($urandom_range(3, 1000));
        if (a < NCHK && $urandom_range(0, 1) == 1) d = expected[int'(a)*DW +: DW];
        else d = DW'($urandom_range(0, 15));
        if ($urandom_range(0, 60) == 0) do_reset();
        cyc($urandom_range(0, 2) != 0, a, d);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tb_multi_result_checker.md
# tb_multi_result_checker

Parametrised, synthesizable memory-write result checker for the branch-predictor and extension test benches. It monitors the CPU data-memory write port and compares writes inside a window of NUM_CHK consecutive word addresses against a supplied expected-value vector. It de-duplicates writes held across D-cache stalls, counts mismatches, and measures run duration. It raises finish/pass, or flags a timeout.

## Interface
- ADDR_W, 30, word-address width
- DATA_W, 32, data width
- NUM_CHK, 4, number of checked words (1..16)
- BASE_ADDR, 0, word address of check slot 0
- TIMEOUT, 16'hFFFF, duration value that forces termination
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- addr  in  ADDR_W  data-memory word address
- data  in  DATA_W  data-memory write data
- wen  in  1  data-memory write enable (may stay high for several cycles during a stall)
- expected  in  NUM_CHK*DATA_W  expected values, slot i at bits [i*DATA_W +: DATA_W]; static during a run
- error_num  out  8  mismatching slots so far, saturating at 255
- duration  out  16  clock edges spent in RUN, saturating at 16'hFFFF
- checked  out  NUM_CHK  bit i set once slot i has been written
- finish  out  1  run terminated (all checked or timeout)
- pass  out  1  finish & no errors & no timeout
- timeout  out  1  run terminated by TIMEOUT

## Operation
- Reset values: state RUN, wen_q 0, error_num 0, duration 0, checked 0, finish 0, pass 0, timeout 0.
- Write edge detect: wen_q <= wen every edge. accept = wen & ~wen_q. A write held high over N cycles counts once. A new write needs wen to drop for at least one cycle.
- In-window: BASE_ADDR <= addr < BASE_ADDR+NUM_CHK. Compute index = addr - BASE_ADDR, ADDR_W-bit unsigned. Out-of-window accepts are ignored.
- Slot update on an accepted in-window write with checked[index]==0:
  - set checked[index].
  - if data != expected slot, error_num += 1, saturating.
- Accepted writes to an already-checked slot are ignored; the first write wins.
- States:
  - RUN: duration += 1 (saturating) on every edge, except the edge that moves to DONE.
  - RUN -> DONE when checked becomes all-ones, including via the current accept. This is completion.
  - RUN -> DONE when duration == TIMEOUT and completion does not occur on the same edge. This sets timeout=1.
  - DONE: every register frozen; accepts are ignored; sticky until rst.
- If completion and timeout coincide, completion wins and timeout stays 0.
- finish = (state==DONE). pass = finish & (error_num==0) & ~timeout. Both are combinational from registers.
- Reset mid-run asynchronously clears all state. The first accept after rst release is judged against wen_q=0.

## Timing
- Accept decision is combinational on cycle n inputs. checked and error_num update at the end of cycle n (the next posedge).
- finish, pass and timeout go high on the same posedge that records the last slot, or on the timeout edge.
- duration equals the number of RUN edges before the terminating edge. With no completion, timeout asserts at the edge after duration reaches TIMEOUT.
- Display/$finish hooks, if any, live in the bench on negedge clk and are not part of this block.

## Test plan
- NUM_CHK=2, expected={5,60}. Write 60@0 at cycle 3, then 5@1 at cycle 6, each wen one cycle wide. Required: error_num=0, checked=2'b11, finish=pass=1 after the cycle-6 edge, duration=6.
- Same config. Hold wen high for 4 cycles writing 60@0 (stall), then write 5@1. Required: single accept for slot 0, error_num=0, pass=1.
- Same config. Write 61@0, then 60@0, then 5@1. Required: error_num=1 (first write wins), finish=1, pass=0, timeout=0.
- Writes to addresses 7 and 2 only, TIMEOUT=20. Required: checked=0, error_num=0, timeout=finish=1 and pass=0 after edge 21, duration frozen at 20.
- Completing write accepted on the same edge duration hits TIMEOUT. Required: timeout=0, pass=1.
- Assert rst low mid-run after one mismatch. Required: all outputs 0 immediately; a correct rerun gives pass=1.
